// File: rtl/soc_rst_sequencer_pkg.sv
// Shared definitions for the SoC reset sequencer: state encoding and sizing helpers.
package soc_rst_sequencer_pkg;

    localparam logic [2:0] ST_WAIT_LOCK   = 3'd0;
    localparam logic [2:0] ST_LOCK_STABLE = 3'd1;
    localparam logic [2:0] ST_HOLD        = 3'd2;
    localparam logic [2:0] ST_RUN         = 3'd3;
    localparam logic [2:0] ST_DONE        = 3'd4;

    typedef enum logic [2:0] {
        WAIT_LOCK   = ST_WAIT_LOCK,
        LOCK_STABLE = ST_LOCK_STABLE,
        HOLD        = ST_HOLD,
        RUN         = ST_RUN,
        DONE        = ST_DONE
    } state_e;

    localparam int unsigned RST_COUNT_W = 8;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/soc_rst_sequencer_btn_debounce.sv
// Pushbutton conditioning: 2-flop synchronizer, level debounce and a one-cycle press pulse.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic btn_i,
    output logic press_o
);

    localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync_meta_q;
    logic          btn_s_q;
    logic          btn_d_q;
    logic          btn_d_d;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // The run length restarts whenever the synchronized level agrees with the accepted one.
    always_comb begin
        cnt_d   = '0;
        btn_d_d = btn_d_q;
        press_d = 1'b0;
        if (btn_s_q != btn_d_q) begin
            if (cnt_q == CNT_LAST) begin
                btn_d_d = btn_s_q;
                press_d = btn_s_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync_meta_q <= 1'b0;
            btn_s_q     <= 1'b0;
            btn_d_q     <= 1'b0;
            press_q     <= 1'b0;
            cnt_q       <= '0;
        end else begin
            sync_meta_q <= btn_i;
            btn_s_q     <= sync_meta_q;
            btn_d_q     <= btn_d_d;
            press_q     <= press_d;
            cnt_q       <= cnt_d;
        end
    end

    assign press_o = press_q;

endmodule

// File: rtl/soc_rst_sequencer.sv
// Power-on/pushbutton reset sequencer: waits for a stable PLL lock, holds SoC reset, then runs.
module soc_rst_sequencer
    import soc_rst_sequencer_pkg::*;
#(
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned RST_HOLD_CYCLES    = 64,
    parameter int unsigned DEBOUNCE_CYCLES    = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   pll_locked_i,
    input  logic                   btn_rst_i,
    input  logic                   exit_valid_i,
    input  logic                   exit_value_i,
    output logic                   soc_rst_no,
    output logic                   rst_led_o,
    output logic [2:0]             state_o,
    output logic                   exit_value_o,
    output logic [RST_COUNT_W-1:0] rst_count_o
);

    localparam int unsigned CNT_W = $clog2(max_u(LOCK_STABLE_CYCLES, RST_HOLD_CYCLES)) + 1;
    localparam logic [CNT_W-1:0] LOCK_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [RST_COUNT_W-1:0] COUNT_MAX = '1;

    state_e                 state_q;
    state_e                 state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [CNT_W-1:0]       cnt_d;
    logic                   lock_meta_q;
    logic                   lock_s_q;
    logic                   exit_valid_q;
    logic                   exit_value_q;
    logic                   exit_value_d;
    logic [RST_COUNT_W-1:0] rst_count_q;
    logic [RST_COUNT_W-1:0] rst_count_d;
    logic                   soc_rst_no_q;
    logic                   press;
    logic                   exit_edge;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_btn_debounce (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .btn_i  (btn_rst_i),
        .press_o(press)
    );

    assign exit_edge = exit_valid_i & ~exit_valid_q;

    // Lock loss outranks a press, so a press arriving with lock loss is never counted.
    always_comb begin
        state_d      = state_q;
        cnt_d        = '0;
        exit_value_d = exit_value_q;
        rst_count_d  = rst_count_q;
        unique case (state_q)
            WAIT_LOCK: begin
                if (lock_s_q) begin
                    state_d = LOCK_STABLE;
                end
            end
            LOCK_STABLE: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == LOCK_LAST) begin
                    state_d = HOLD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            HOLD: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RUN: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (press) begin
                    state_d = HOLD;
                    if (rst_count_q != COUNT_MAX) begin
                        rst_count_d = rst_count_q + 1'b1;
                    end
                end else if (exit_edge) begin
                    state_d      = DONE;
                    exit_value_d = exit_value_i;
                end
            end
            DONE: begin
                if (!lock_s_q) begin
                    state_d = WAIT_LOCK;
                end else if (press) begin
                    state_d = HOLD;
                    if (rst_count_q != COUNT_MAX) begin
                        rst_count_d = rst_count_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
        if (state_d == HOLD && state_q != HOLD) begin
            exit_value_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= WAIT_LOCK;
            cnt_q        <= '0;
            lock_meta_q  <= 1'b0;
            lock_s_q     <= 1'b0;
            exit_valid_q <= 1'b0;
            exit_value_q <= 1'b0;
            rst_count_q  <= '0;
            soc_rst_no_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            lock_meta_q  <= pll_locked_i;
            lock_s_q     <= lock_meta_q;
            exit_valid_q <= exit_valid_i;
            exit_value_q <= exit_value_d;
            rst_count_q  <= rst_count_d;
            soc_rst_no_q <= (state_d == RUN) || (state_d == DONE);
        end
    end

    assign soc_rst_no   = soc_rst_no_q;
    assign rst_led_o    = soc_rst_no_q;
    assign state_o      = state_q;
    assign exit_value_o = exit_value_q;
    assign rst_count_o  = rst_count_q;

endmodule

// File: tb/tb_soc_rst_sequencer.sv
// Self-checking bench for soc_rst_sequencer against a cycle-level behavioural model.
module tb_soc_rst_sequencer;

    localparam int LSC = 8;
    localparam int RHC = 4;
    localparam int DBC = 3;

    logic       clk = 1'b0;
    logic       rst_i = 1'b1;
    logic       pll_locked_i = 1'b0;
    logic       btn_rst_i = 1'b0;
    logic       exit_valid_i = 1'b0;
    logic       exit_value_i = 1'b0;
    logic       soc_rst_no;
    logic       rst_led_o;
    logic [2:0] state_o;
    logic       exit_value_o;
    logic [7:0] rst_count_o;
    logic [13:0] dut_obs;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    soc_rst_sequencer #(
        .LOCK_STABLE_CYCLES(LSC),
        .RST_HOLD_CYCLES   (RHC),
        .DEBOUNCE_CYCLES   (DBC)
    ) dut (
        .clk_i       (clk),
        .rst_i       (rst_i),
        .pll_locked_i(pll_locked_i),
        .btn_rst_i   (btn_rst_i),
        .exit_valid_i(exit_valid_i),
        .exit_value_i(exit_value_i),
        .soc_rst_no  (soc_rst_no),
        .rst_led_o   (rst_led_o),
        .state_o     (state_o),
        .exit_value_o(exit_value_o),
        .rst_count_o (rst_count_o)
    );

    assign dut_obs = {state_o, soc_rst_no, rst_led_o, exit_value_o, rst_count_o};

    // Behavioural model: states as plain numbers, time spent in a state, length of a button disagreement.
    int m_state = 0, m_in_state = 0, m_diff_run = 0, m_count = 0;
    bit m_lk1 = 0, m_lks = 0, m_bt1 = 0, m_bts = 0, m_btd = 0, m_press = 0;
    bit m_xv_prev = 0, m_soc = 0, m_xo = 0;

    task automatic model_update();
        int ns;
        bit new_press;
        if (rst_i) begin
            m_state = 0; m_in_state = 0; m_diff_run = 0; m_count = 0;
            m_lk1 = 0; m_lks = 0; m_bt1 = 0; m_bts = 0; m_btd = 0; m_press = 0;
            m_xv_prev = 0; m_soc = 0; m_xo = 0;
        end else begin
            new_press = 0;
            if (m_bts != m_btd) m_diff_run++;
            else m_diff_run = 0;
            ns = m_state;
            if (m_state != 0 && !m_lks) ns = 0;
            else if (m_state == 0 && m_lks) ns = 1;
            else if (m_state == 1 && m_in_state + 1 == LSC) ns = 2;
            else if (m_state == 2 && m_in_state + 1 == RHC) ns = 3;
            else if (m_state >= 3 && m_press) begin
                ns = 2;
                if (m_count < 255) m_count++;
            end else if (m_state == 3 && exit_valid_i && !m_xv_prev) begin
                ns = 4;
                m_xo = exit_value_i;
            end
            if (ns == 2 && m_state != 2) m_xo = 0;
            m_in_state = (ns == m_state) ? m_in_state + 1 : 0;
            m_state = ns;
            m_soc = (ns >= 3);
            if (m_diff_run == DBC) begin
                new_press = !m_btd;
                m_btd = !m_btd;
                m_diff_run = 0;
            end
            m_press = new_press;
            m_lks = m_lk1; m_lk1 = pll_locked_i;
            m_bts = m_bt1; m_bt1 = btn_rst_i;
            m_xv_prev = exit_valid_i;
        end
    endtask

    function automatic logic [13:0] mdl_obs();
        logic [2:0] s;
        logic [7:0] c;
        s = 3'(m_state);
        c = 8'(m_count);
        return {s, m_soc, m_soc, m_xo, c};
    endfunction

    task automatic step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_i = 1; pll_locked_i = 1; btn_rst_i = 1; exit_valid_i = 1; exit_value_i = 1;
        step(); step();
        checks++;
        if (dut_obs !== 14'h0) begin
            errors++; $display("FAIL reset_state: got %h expected %h", dut_obs, 14'h0);
        end
        checks++;
        if (dut_obs !== mdl_obs()) begin
            errors++; $display("FAIL reset_model: got %h expected %h", dut_obs, mdl_obs());
        end
        btn_rst_i = 0; exit_valid_i = 0; exit_value_i = 0; pll_locked_i = 0;
        step();
    endtask

    task automatic test_power_up();
        int exp_st;
        rst_i = 1; step();
        rst_i = 0; pll_locked_i = 1;
        for (int e = 1; e <= 18; e++) begin
            step();
            exp_st = (e < 3) ? 0 : (e < 11) ? 1 : (e < 15) ? 2 : 3;
            checks++;
            if (state_o !== 3'(exp_st) || soc_rst_no !== (e >= 15)) begin
                errors++;
                $display("FAIL power_up edge %0d: got state=%0d rst_n=%b expected state=%0d rst_n=%b",
                         e, state_o, soc_rst_no, exp_st, (e >= 15));
            end
            checks++;
            if (dut_obs !== mdl_obs()) begin
                errors++; $display("FAIL power_up_model edge %0d: got %h expected %h", e, dut_obs, mdl_obs());
            end
        end
    endtask

    task automatic test_lock_glitch();
        int exp_st;
        rst_i = 1; step();
        rst_i = 0; pll_locked_i = 1;
        for (int e = 1; e <= 26; e++) begin
            if (e == 9) pll_locked_i = 0;
            if (e == 10) pll_locked_i = 1;
            step();
            exp_st = (e < 3) ? 0 : (e < 11) ? 1 : (e == 11) ? 0 : (e < 20) ? 1 : (e < 24) ? 2 : 3;
            checks++;
            if (state_o !== 3'(exp_st) || soc_rst_no !== (e >= 24)) begin
                errors++;
                $display("FAIL lock_glitch edge %0d: got state=%0d rst_n=%b expected state=%0d rst_n=%b",
                         e, state_o, soc_rst_no, exp_st, (e >= 24));
            end
            checks++;
            if (dut_obs !== mdl_obs()) begin
                errors++; $display("FAIL lock_glitch_model edge %0d: got %h expected %h", e, dut_obs, mdl_obs());
            end
        end
    endtask

    task automatic test_press();
        int low = 0;
        for (int i = 0; i < 12; i++) begin
            btn_rst_i = (i < 2);
            step();
            checks++;
            if (dut_obs !== mdl_obs()) begin
                errors++; $display("FAIL glitch_model cyc %0d: got %h expected %h", i, dut_obs, mdl_obs());
            end
        end
        checks++;
        if (state_o !== 3'd3 || rst_count_o !== 8'd0) begin
            errors++; $display("FAIL glitch_ignored: got state=%0d count=%0d expected state=3 count=0", state_o, rst_count_o);
        end
        for (int i = 0; i < 20; i++) begin
            btn_rst_i = (i < 10);
            step();
            if (soc_rst_no === 1'b0) low++;
            checks++;
            if (dut_obs !== mdl_obs()) begin
                errors++; $display("FAIL press_model cyc %0d: got %h expected %h", i, dut_obs, mdl_obs());
            end
        end
        checks++;
        if (low != RHC || rst_count_o !== 8'd1 || state_o !== 3'd3) begin
            errors++;
            $display("FAIL press_hold: got low=%0d count=%0d state=%0d expected low=%0d count=1 state=3",
                     low, rst_count_o, state_o, RHC);
        end
    endtask

    task automatic test_exit();
        int hold_cyc = 0;
        exit_valid_i = 1; exit_value_i = 1;
        step();
        checks++;
        if (state_o !== 3'd4 || exit_value_o !== 1'b1 || soc_rst_no !== 1'b1) begin
            errors++;
            $display("FAIL exit_done: got state=%0d xv=%b rst_n=%b expected state=4 xv=1 rst_n=1",
                     state_o, exit_value_o, soc_rst_no);
        end
        for (int i = 0; i < 6; i++) begin
            exit_valid_i = i[0]; exit_value_i = 0;
            step();
            checks++;
            if (state_o !== 3'd4 || exit_value_o !== 1'b1) begin
                errors++; $display("FAIL exit_hold cyc %0d: got state=%0d xv=%b expected state=4 xv=1", i, state_o, exit_value_o);
            end
        end
        exit_valid_i = 0;
        for (int i = 0; i < 20; i++) begin
            btn_rst_i = (i < 10);
            step();
            if (state_o === 3'd2) begin
                hold_cyc++;
                checks++;
                if (exit_value_o !== 1'b0) begin
                    errors++; $display("FAIL exit_clear cyc %0d: got xv=%b expected xv=0", i, exit_value_o);
                end
            end
            checks++;
            if (dut_obs !== mdl_obs()) begin
                errors++; $display("FAIL exit_model cyc %0d: got %h expected %h", i, dut_obs, mdl_obs());
            end
        end
        checks++;
        if (hold_cyc != RHC || rst_count_o !== 8'd2 || state_o !== 3'd3) begin
            errors++;
            $display("FAIL exit_press: got hold=%0d count=%0d state=%0d expected hold=%0d count=2 state=3",
                     hold_cyc, rst_count_o, state_o, RHC);
        end
    endtask

    task automatic test_lock_and_press();
        btn_rst_i = 1;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) pll_locked_i = 0;
            step();
            checks++;
            if (dut_obs !== mdl_obs()) begin
                errors++; $display("FAIL lock_press_model cyc %0d: got %h expected %h", i, dut_obs, mdl_obs());
            end
        end
        checks++;
        if (state_o !== 3'd0 || rst_count_o !== 8'd2 || soc_rst_no !== 1'b0) begin
            errors++;
            $display("FAIL lock_press: got state=%0d count=%0d rst_n=%b expected state=0 count=2 rst_n=0",
                     state_o, rst_count_o, soc_rst_no);
        end
        btn_rst_i = 0; pll_locked_i = 1;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if (dut_obs !== mdl_obs()) begin
                errors++; $display("FAIL relock_model cyc %0d: got %h expected %h", i, dut_obs, mdl_obs());
            end
        end
    endtask

    task automatic test_reset_midrun();
        exit_valid_i = 1; exit_value_i = 1;
        step();
        checks++;
        if (state_o !== 3'd4) begin
            errors++; $display("FAIL midrun_done: got state=%0d expected state=4", state_o);
        end
        rst_i = 1;
        step();
        checks++;
        if (dut_obs !== 14'h0) begin
            errors++; $display("FAIL midrun_reset: got %h expected %h", dut_obs, 14'h0);
        end
        rst_i = 0; exit_valid_i = 0; exit_value_i = 0;
        for (int e = 1; e <= 16; e++) begin
            step();
            checks++;
            if (soc_rst_no !== (e >= 15) || dut_obs !== mdl_obs()) begin
                errors++;
                $display("FAIL midrun_restart edge %0d: got %h expected %h", e, dut_obs, mdl_obs());
            end
        end
    endtask

    task automatic test_saturate();
        int h, l;
        for (int p = 0; p < 300; p++) begin
            h = 4 + $urandom_range(0, 3);
            l = 4 + $urandom_range(0, 3);
            for (int c = 0; c < h + l; c++) begin
                btn_rst_i = (c < h);
                step();
                checks++;
                if (dut_obs !== mdl_obs()) begin
                    errors++; $display("FAIL saturate_model press %0d cyc %0d: got %h expected %h", p, c, dut_obs, mdl_obs());
                end
            end
        end
        repeat (6) step();
        checks++;
        if (rst_count_o !== 8'd255 || state_o !== 3'd3) begin
            errors++; $display("FAIL saturate: got count=%0d state=%0d expected count=255 state=3", rst_count_o, state_o);
        end
        exit_valid_i = 1;
        step();
        exit_valid_i = 0;
        pll_locked_i = 0;
        repeat (6) step();
        checks++;
        if (state_o !== 3'd0 || rst_count_o !== 8'd255 || soc_rst_no !== 1'b0) begin
            errors++;
            $display("FAIL done_lock_loss: got state=%0d count=%0d rst_n=%b expected state=0 count=255 rst_n=0",
                     state_o, rst_count_o, soc_rst_no);
        end
        pll_locked_i = 1;
    endtask

    task automatic test_random();
        int lock_off = 0;
        for (int i = 0; i < 3000; i++) begin
            if (lock_off > 0) begin
                lock_off--;
                pll_locked_i = (lock_off == 0);
            end else if ($urandom_range(0, 299) == 0) begin
                lock_off = $urandom_range(1, 20);
                pll_locked_i = 0;
            end
            if ($urandom_range(0, 5) == 0) btn_rst_i = ~btn_rst_i;
            if ($urandom_range(0, 9) == 0) exit_valid_i = ~exit_valid_i;
            exit_value_i = 1'($urandom_range(0, 1));
            rst_i = ($urandom_range(0, 999) == 0);
            step();
            checks++;
            if (dut_obs !== mdl_obs()) begin
                errors++; $display("FAIL random_model cyc %0d: got %h expected %h", i, dut_obs, mdl_obs());
            end
        end
        rst_i = 0;
    endtask

    initial begin
        test_reset();
        test_power_up();
        test_lock_glitch();
        test_press();
        test_exit();
        test_lock_and_press();
        test_reset_midrun();
        test_saturate();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
